floating_divider: RTL and testbench
===================================

// Module: floating_divider
// PURPOSE
//  Sequential IEEE-754 single-precision divider: quotient = num1 / num2.
//  Inverse companion of floating_multiplier; shares its operand format (sign, 8-bit exp, 23-bit mantissa).
//  Iterative restoring mantissa division, one quotient bit per clock, with a start/busy/done handshake.
//  Sits beside the multiplier in the FP datapath; the caller holds the result after done.
// PARAMETERS
//  ROUND_EN  1  1 = round half-up on guard bit (same rule as multiplier); 0 = truncate
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   request; sampled only in IDLE
//  num1      in   32  dividend (IEEE-754 single)
//  num2      in   32  divisor  (IEEE-754 single)
//  busy      out  1   high from the cycle after start is accepted until done
//  done      out  1   one-cycle pulse: quotient valid
//  quotient  out  32  result; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, quotient=32'h0, all internal regs cleared.
//  Deassertion of rst_n is synchronous to clk by the surrounding reset logic.
//  FSM: IDLE -> DIVIDE -> NORM -> IDLE.
//   IDLE:   start=1 at edge k: latch num1/num2, sign=s1^s2, decode specials, load remainder={1,m1},
//           divisor={1,m2}; busy=1 next. start=0: stay, done=0.
//   DIVIDE: 26 cycles (edges k+1..k+26). Each cycle: if rem>=div then rem-=div, qbit=1 else qbit=0;
//           rem<<=1; q={q,qbit}. Yields q[25:0]: 1 integer bit + 25 fraction bits; value in (0.5,2).
//   NORM:   edge k+27: normalize, round, pack, register quotient; done=1, busy=0 for that cycle; ->IDLE.
//  Latency: fixed 27 cycles from start edge to done, for every operand class including specials.
//  start while busy: ignored (no queueing, no restart). Inputs may change after the start edge.
//  Arithmetic (exponent in 10-bit signed):
//   e = e1 - e2 + 127.
//   q[25]=1: mant=q[24:2], guard=q[1].  q[25]=0: mant=q[23:1], guard=q[0], e=e-1.
//   ROUND_EN=1 and guard=1: mant+=1; carry out of mant (all ones) -> mant=0, e=e+1.
//   e>=255 -> signed infinity {sign,8'hFF,23'h0}. e<=0 -> signed zero {sign,31'h0}.
//  Special operands (decoded at start; exp 0 = zero, denormals flushed to zero):
//   either NaN, 0/0, inf/inf -> 32'h7FC00000 (sign forced 0).
//   x/0 (x nonzero finite) or inf/x -> {sign,8'hFF,23'h0}.
//   0/x or x/inf -> {sign,31'h0}.
//   Special results still traverse DIVIDE (datapath result discarded) to keep latency uniform.
//  Reset mid-operation: immediate abort to IDLE; no done pulse; quotient=0.
//  done never asserted without a preceding accepted start; done and busy never high together.
//  No $monitor/$display in synthesizable body.
// TESTING
//  6.0/2.0: num1=40C00000 num2=40000000, start -> done 27 cycles later, quotient=40400000.
//  1.0/3.0: 3F800000/40400000 -> 3EAAAAAB (ROUND_EN=1); 3EAAAAAA (ROUND_EN=0).
//  Specials: BF800000/00000000 -> FF800000; 00000000/00000000 -> 7FC00000;
//   40000000/7F800000 -> 00000000; each with done exactly 27 cycles after start.
//  Overflow/underflow: 7F000000/3E800000 -> 7F800000; 00800000/4B000000 -> 00000000.
//  Handshake: pulse start again at cycles 5 and 20 of a division -> ignored, single done,
//   result of first operands; quotient stable until next start.
//  Reset mid-divide: drop rst_n at cycle 10 -> busy=0, done=0, quotient=0 asynchronously;
//   fresh start after release produces a correct result with full 27-cycle latency.

Source files
------------

// File: rtl/floating_divider.sv
// Sequential IEEE-754 single-precision divider, quotient = num1 / num2.
// Restoring mantissa division, one quotient bit per clock, fixed 27-cycle latency.
module floating_divider #(
   parameter bit ROUND_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_NORM
   } state_t;

   typedef enum logic [1:0] {
      K_NUM,
      K_NAN,
      K_INF,
      K_ZERO
   } kind_t;

   state_t state, state_nx;
   kind_t  kind, kind_d;

   logic              sign;
   logic signed [9:0] exp_r;
   logic [24:0]       rem;
   logic [23:0]       dvs;
   logic [25:0]       q;
   logic [4:0]        cnt;

   logic [7:0]  e1, e2;
   logic [22:0] m1, m2;
   logic        nan1, nan2, inf1, inf2, zro1, zro2;

   assign e1 = num1[30:23];
   assign e2 = num2[30:23];
   assign m1 = num1[22:0];
   assign m2 = num2[22:0];

   assign nan1 = (e1 == 8'hFF) && (m1 != 23'd0);
   assign nan2 = (e2 == 8'hFF) && (m2 != 23'd0);
   assign inf1 = (e1 == 8'hFF) && (m1 == 23'd0);
   assign inf2 = (e2 == 8'hFF) && (m2 == 23'd0);
   assign zro1 = (e1 == 8'h00);
   assign zro2 = (e2 == 8'h00);

   // Class precedence: NaN-producing cases first, then infinities, then zeros
   always_comb begin
      kind_d = K_NUM;
      if (nan1 || nan2 || (zro1 && zro2) || (inf1 && inf2))
         kind_d = K_NAN;
      else if (inf1 || zro2)
         kind_d = K_INF;
      else if (zro1 || inf2)
         kind_d = K_ZERO;
   end

   logic [25:0] diff;
   logic        ge;
   logic [24:0] rem_nx;

   assign diff   = {1'b0, rem} - {2'b00, dvs};
   assign ge     = ~diff[25];
   assign rem_nx = ge ? diff[24:0] : rem;

   logic [22:0]       mant0;
   logic              guard;
   logic signed [9:0] e_n;
   logic [23:0]       mant_r;
   logic signed [9:0] e_f;
   logic [31:0]       packed_q;

   always_comb begin
      mant0 = q[24:2];
      guard = q[1];
      e_n   = exp_r;
      if (!q[25]) begin
         mant0 = q[23:1];
         guard = q[0];
         e_n   = exp_r - 10'sd1;
      end
      mant_r = {1'b0, mant0} + {23'd0, (ROUND_EN && guard)};
      e_f    = mant_r[23] ? (e_n + 10'sd1) : e_n;
      if (e_f >= 10'sd255)
         packed_q = {sign, 8'hFF, 23'd0};
      else if (e_f <= 10'sd0)
         packed_q = {sign, 31'd0};
      else
         packed_q = {sign, e_f[7:0], mant_r[22:0]};
      unique case (kind)
         K_NAN:   packed_q = 32'h7FC0_0000;
         K_INF:   packed_q = {sign, 8'hFF, 23'd0};
         K_ZERO:  packed_q = {sign, 31'd0};
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (start) state_nx = S_DIVIDE;
         S_DIVIDE: if (cnt == 5'd25) state_nx = S_NORM;
         S_NORM:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign     <= 1'b0;
         kind     <= K_NUM;
         exp_r    <= '0;
         rem      <= '0;
         dvs      <= '0;
         q        <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sign  <= num1[31] ^ num2[31];
                  kind  <= kind_d;
                  exp_r <= $signed({2'b00, e1}) - $signed({2'b00, e2})
                           + 10'sd127;
                  rem   <= {2'b01, m1};
                  dvs   <= {1'b1, m2};
                  q     <= '0;
                  cnt   <= '0;
               end
            end
            S_DIVIDE: begin
               rem <= rem_nx << 1;
               q   <= {q[24:0], ge};
               cnt <= cnt + 5'd1;
            end
            S_NORM: begin
               quotient <= packed_q;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_floating_divider.sv
// Bench for floating_divider: directed vectors, random operands vs model,
// handshake, hold and mid-operation reset scenarios.
module tb_floating_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num1 = '0;
   logic [31:0] num2 = '0;
   logic        busy, done, busy_t, done_t;
   logic [31:0] quotient, quotient_t;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   floating_divider #(.ROUND_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .num1(num1), .num2(num2),
      .busy(busy), .done(done), .quotient(quotient)
   );

   floating_divider #(.ROUND_EN(1'b0)) dut_t (
      .clk(clk), .rst_n(rst_n), .start(start),
      .num1(num1), .num2(num2),
      .busy(busy_t), .done(done_t), .quotient(quotient_t)
   );

   function automatic logic [31:0] ref_div(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit rnd);
      int ea, eb, e;
      longint ma, mb, qq, mant;
      bit s, g;
      bit an, bn, ai, bi, az, bz;
      logic [7:0] eo;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = longint'(a[22:0]);
      mb = longint'(b[22:0]);
      s  = a[31] ^ b[31];
      an = (ea == 255) && (ma != 0);
      bn = (eb == 255) && (mb != 0);
      ai = (ea == 255) && (ma == 0);
      bi = (eb == 255) && (mb == 0);
      az = (ea == 0);
      bz = (eb == 0);
      if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC0_0000;
      if (ai || bz) return {s, 8'hFF, 23'd0};
      if (az || bi) return {s, 31'd0};
      qq = ((ma + 64'd8388608) * 64'd33554432) / (mb + 64'd8388608);
      e  = ea - eb + 127;
      if (qq >= 64'd33554432) begin
         mant = (qq / 4) % 64'd8388608;
         g    = qq[1];
      end else begin
         mant = (qq / 2) % 64'd8388608;
         g    = qq[0];
         e    = e - 1;
      end
      if (rnd && g) begin
         mant = mant + 1;
         if (mant == 64'd8388608) begin
            mant = 0;
            e    = e + 1;
         end
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      eo = e[7:0];
      return {s, eo, mant[22:0]};
   endfunction

   // Issues one division; reports both results, latency and handshake errors
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input bit glitch,
                          output logic [31:0] r1, output logic [31:0] r0,
                          output int lat, output bit bad_hs);
      num1 = a;
      num2 = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      num1 = $urandom;
      num2 = $urandom;
      lat = 0;
      bad_hs = !busy || !busy_t || done || done_t;
      for (int n = 1; n <= 40; n++) begin
         if (glitch && (n == 5 || n == 20)) begin
            start = 1'b1;
            num1 = 32'h3F80_0000;
            num2 = 32'h4000_0000;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done !== done_t || busy !== busy_t) bad_hs = 1'b1;
         if (done && busy) bad_hs = 1'b1;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) bad_hs = 1'b1;
      end
      r1 = quotient;
      r0 = quotient_t;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({busy, done, busy_t, done_t} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 0000",
                  {busy, done, busy_t, done_t});
      end
      checks++;
      if (quotient !== 32'h0 || quotient_t !== 32'h0) begin
         failures++;
         $display("FAIL reset_q: got %h/%h want 0", quotient, quotient_t);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [31:0] tv [8][4];
      logic [31:0] r1, r0;
      int lat;
      bit bad;
      tv[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000};
      tv[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32'h3EAA_AAAA};
      tv[2] = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 32'hFF80_0000};
      tv[3] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000};
      tv[4] = '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
      tv[5] = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 32'h7F80_0000};
      tv[6] = '{32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 32'h0000_0000};
      tv[7] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
      for (int i = 0; i < 8; i++) begin
         run_div(tv[i][0], tv[i][1], 1'b0, r1, r0, lat, bad);
         checks++;
         if (lat != 27 || bad) begin
            failures++;
            $display("FAIL dir_lat[%0d]: got lat=%0d hs_err=%0b want 27/0",
                     i, lat, bad);
         end
         checks++;
         if (r1 !== tv[i][2] || r0 !== tv[i][3]) begin
            failures++;
            $display("FAIL dir_q[%0d]: got %h/%h want %h/%h",
                     i, r1, r0, tv[i][2], tv[i][3]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || done_t !== 1'b0) begin
            failures++;
            $display("FAIL dir_pulse[%0d]: got done=%b want 0", i, done);
         end
      end
   endtask

   function automatic logic [31:0] rand_fp();
      logic [7:0] e;
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 0) e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      else if (mode == 1) e = 8'($urandom_range(1, 20));
      else if (mode == 2) e = 8'($urandom_range(235, 254));
      else e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e,
              ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
   endfunction

   task automatic test_random_back_to_back();
      logic [31:0] a, b, r1, r0;
      int lat;
      bit bad;
      for (int i = 0; i < 150; i++) begin
         a = rand_fp();
         b = rand_fp();
         run_div(a, b, 1'b0, r1, r0, lat, bad);
         checks++;
         if (lat != 27 || bad) begin
            failures++;
            $display("FAIL rnd_lat[%0d]: got lat=%0d hs_err=%0b want 27/0",
                     i, lat, bad);
         end
         checks++;
         if (r1 !== ref_div(a, b, 1'b1)) begin
            failures++;
            $display("FAIL rnd_q_round %h/%h: got %h want %h",
                     a, b, r1, ref_div(a, b, 1'b1));
         end
         checks++;
         if (r0 !== ref_div(a, b, 1'b0)) begin
            failures++;
            $display("FAIL rnd_q_trunc %h/%h: got %h want %h",
                     a, b, r0, ref_div(a, b, 1'b0));
         end
      end
   endtask

   task automatic test_handshake_hold();
      logic [31:0] r1, r0;
      int lat;
      bit bad, extra;
      run_div(32'h40C0_0000, 32'h4040_0000, 1'b1, r1, r0, lat, bad);
      checks++;
      if (lat != 27 || bad) begin
         failures++;
         $display("FAIL hs_lat: got lat=%0d hs_err=%0b want 27/0", lat, bad);
      end
      checks++;
      if (r1 !== 32'h4000_0000 || r0 !== 32'h4000_0000) begin
         failures++;
         $display("FAIL hs_q: got %h/%h want 40000000", r1, r0);
      end
      extra = 1'b0;
      for (int n = 0; n < 40; n++) begin
         num1 = $urandom;
         num2 = $urandom;
         @(posedge clk);
         #1;
         if (done || busy || done_t || quotient !== r1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL hs_hold: got extra activity/q=%h want idle/%h",
                  quotient, r1);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r1, r0;
      int lat;
      bit bad;
      num1 = 32'h40C0_0000;
      num2 = 32'h4000_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, busy_t, done_t} !== 4'b0 ||
          quotient !== 32'h0 || quotient_t !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid: got b=%b d=%b q=%h want 0/0/0",
                  busy, done, quotient);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (done || busy) begin
         failures++;
         $display("FAIL rst_mid_idle: got b=%b d=%b want 0/0", busy, done);
      end
      run_div(32'h3F80_0000, 32'h4040_0000, 1'b0, r1, r0, lat, bad);
      checks++;
      if (lat != 27 || bad || r1 !== 32'h3EAA_AAAB || r0 !== 32'h3EAA_AAAA) begin
         failures++;
         $display("FAIL rst_mid_rerun: got lat=%0d q=%h/%h want 27 3eaaaaab/3eaaaaaa",
                  lat, r1, r0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_back_to_back();
      test_handshake_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
